// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART serial transmitter: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic [1:0] data_bit_num,
    input  logic       stop_bit_num,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       start_tx,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic          start_q;

    // Frame configuration frozen at acceptance so register writes mid-frame cannot corrupt it
    logic [7:0]    sh_data;
    logic [1:0]    sh_len;
    logic          sh_stop;
    logic          sh_par_en;
    logic          sh_par_type;

    logic          start_req;
    logic          baud_end;
    logic [2:0]    bit_nxt;
    logic [2:0]    data_last;
    logic [7:0]    data_mask;
    logic          parity_bit;

    assign start_req  = start_tx & ~start_q;
    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign bit_nxt    = bit_cnt + 3'd1;
    // Index of the final data bit: 4 for 5-bit words up to 7 for 8-bit words
    assign data_last  = {1'b0, sh_len} + 3'd4;
    // Keep only the N bits that are actually sent so unused high bits cannot flip parity
    assign data_mask  = 8'hFF >> (~sh_len);
    assign parity_bit = (^(sh_data & data_mask)) ^ sh_par_type;

    // Transmit FSM with registered line, status flags, counters and shadow registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= 3'd0;
            start_q     <= 1'b0;
            sh_data     <= 8'h00;
            sh_len      <= 2'b00;
            sh_stop     <= 1'b0;
            sh_par_en   <= 1'b0;
            sh_par_type <= 1'b0;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            start_q <= start_tx;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= 3'd0;
                    tx       <= 1'b1;
                    if (start_req) begin
                        sh_data     <= tx_data;
                        sh_len      <= data_bit_num;
                        sh_stop     <= stop_bit_num;
                        sh_par_en   <= parity_en;
                        sh_par_type <= parity_type;
                        state       <= START;
                        tx          <= 1'b0;
                        tx_busy     <= 1'b1;
                        tx_done     <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= 3'd0;
                        state    <= DATA;
                        tx       <= sh_data[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == data_last) begin
                            bit_cnt <= 3'd0;
                            if (sh_par_en) begin
                                state <= PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_nxt;
                            tx      <= sh_data[bit_nxt];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= 3'd0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        // bit_cnt counts stop bits already sent; sh_stop selects one or two
                        if (bit_cnt == {2'b00, sh_stop}) begin
                            bit_cnt <= 3'd0;
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_nxt;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    bit_cnt  <= 3'd0;
                    tx       <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed self-checking bench for uart_tx_core
module tb_uart_tx_core;

    localparam int CPB = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic       start_tx;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int errors;
    int checks;

    uart_tx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .data_bit_num(data_bit_num),
        .stop_bit_num(stop_bit_num),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .start_tx    (start_tx),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Launch one frame and check every cycle of it; seq[i] is the expected line value of bit slot i.
    // glitch=1 rewrites tx_data and pulses start_tx mid-frame to prove shadowing and request dropping.
    task automatic send(input string name, input logic [7:0] data, input logic [1:0] dbn,
                        input logic stp, input logic pen, input logic ptype,
                        input logic [11:0] seq, input int nbits, input bit glitch);
        logic [11:0] s;
        s            = seq;
        tx_data      = data;
        data_bit_num = dbn;
        stop_bit_num = stp;
        parity_en    = pen;
        parity_type  = ptype;
        start_tx     = 1'b1;
        tick(1);
        start_tx = 1'b0;
        for (int c = 0; c < nbits * CPB; c++) begin
            chk($sformatf("%s tx c%0d", name, c), {7'd0, tx}, {7'd0, s[c / CPB]});
            chk($sformatf("%s busy c%0d", name, c), {7'd0, tx_busy}, 8'd1);
            chk($sformatf("%s done c%0d", name, c), {7'd0, tx_done}, 8'd0);
            if (glitch && c == 10) begin
                tx_data  = 8'hFF;
                start_tx = 1'b1;
            end
            if (glitch && c == 12) start_tx = 1'b0;
            tick(1);
        end
        chk({name, " end tx"}, {7'd0, tx}, 8'd1);
        chk({name, " end busy"}, {7'd0, tx_busy}, 8'd0);
        chk({name, " end done"}, {7'd0, tx_done}, 8'd1);
    endtask

    // Directed sequence: reset, frame formats, shadowing, back-to-back, async reset mid-frame
    initial begin
        errors       = 0;
        checks       = 0;
        reset_n      = 1'b0;
        tx_data      = 8'h00;
        data_bit_num = 2'b11;
        stop_bit_num = 1'b0;
        parity_en    = 1'b0;
        parity_type  = 1'b0;
        start_tx     = 1'b0;
        tick(3);
        chk("reset tx", {7'd0, tx}, 8'd1);
        chk("reset busy", {7'd0, tx_busy}, 8'd0);
        chk("reset done", {7'd0, tx_done}, 8'd0);
        reset_n = 1'b1;
        tick(3);
        chk("idle tx", {7'd0, tx}, 8'd1);
        chk("idle busy", {7'd0, tx_busy}, 8'd0);

        // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
        send("8N1_55", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 12'h2AA, 10, 1'b0);
        // back-to-back 8N1 0x0F: 0,1,1,1,1,0,0,0,0,1; start_tx already low for the previous cycle
        send("8N1_0F", 8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 12'h21E, 10, 1'b0);
        tick(1);
        // 7E2 0xA3: 0,1,1,0,0,0,1,0,par 1,1,1
        send("7E2_A3", 8'hA3, 2'b10, 1'b1, 1'b1, 1'b0, 12'h746, 11, 1'b0);
        tick(2);
        // 5O1 0x1F: 0,1,1,1,1,1,par 0,1
        send("5O1_1F", 8'h1F, 2'b00, 1'b0, 1'b1, 1'b1, 12'h0BE, 8, 1'b0);
        tick(1);
        // 8N1 0x00 with data rewrite and start pulse at cycle 10
        send("shadow", 8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 12'h200, 10, 1'b1);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("post-shadow busy c%0d", c), {7'd0, tx_busy}, 8'd0);
            chk($sformatf("post-shadow tx c%0d", c), {7'd0, tx}, 8'd1);
            tick(1);
        end

        // Reset asserted between clock edges at cycle 15 of a 0x00 frame
        tx_data  = 8'h00;
        start_tx = 1'b1;
        tick(1);
        start_tx = 1'b0;
        tick(15);
        chk("pre-reset tx", {7'd0, tx}, 8'd0);
        chk("pre-reset busy", {7'd0, tx_busy}, 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset tx", {7'd0, tx}, 8'd1);
        chk("async reset busy", {7'd0, tx_busy}, 8'd0);
        chk("async reset done", {7'd0, tx_done}, 8'd0);
        tick(2);
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            chk($sformatf("post-reset tx c%0d", c), {7'd0, tx}, 8'd1);
            chk($sformatf("post-reset busy c%0d", c), {7'd0, tx_busy}, 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Serial transmitter of the UART-APB peripheral, directly downstream of the APB register block. Takes the byte, frame configuration and start control from the register block's decoded outputs, serialises an asynchronous frame (start, 5–8 data bits LSB first, optional parity, 1–2 stop bits) on `tx`, and returns a sticky `tx_done` status. The register block samples `tx_done` into its status register.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal minimum is 2. The baud counter width is `$clog2(CLKS_PER_BIT)`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send. Only the low N bits are used.
- `data_bit_num`  in  2  data length: 00=5, 01=6, 10=7, 11=8 bits.
- `stop_bit_num`  in  1  0 = one stop bit, 1 = two stop bits.
- `parity_en`  in  1  1 = insert a parity bit after the data bits.
- `parity_type`  in  1  0 = even, 1 = odd.
- `start_tx`  in  1  start request, level from the control register. Its rising edge launches a frame.
- `tx`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  sticky completion flag.

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state=IDLE, baud counter=0, bit counter=0, start edge register `start_q`=0.
- Start detection: `start_q` <= `start_tx` every cycle. A request is `start_tx & ~start_q`.
  - A request is accepted only in IDLE. A request in any other state is dropped and is not queued.
  - `start_tx` held high through reset release counts as a rising edge.
- On acceptance the block captures `tx_data`, N, `stop_bit_num`, `parity_en` and `parity_type` into shadow registers.
  - Input changes after acceptance do not affect the frame in flight.
  - On acceptance `tx_done` clears to 0 and `tx_busy` sets to 1.
- States:
  - IDLE: `tx`=1. On request → START.
  - START: `tx`=0 for one bit time → DATA.
  - DATA: `tx` = shadow[bit_cnt], starting at bit_cnt 0. After bit N-1 → PARITY if parity enabled, else STOP.
  - PARITY: `tx` = XOR of the N data bits, then XOR with `parity_type`. One bit time → STOP.
  - STOP: `tx`=1 for 1 or 2 bit times → IDLE. On exit `tx_busy`=0 and `tx_done`=1.
- Bit time: the baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state. At CLKS_PER_BIT-1 it wraps to 0 and the bit/state advances. The counter is held at 0 in IDLE.
- The bit counter is 3 bits wide and is reused for stop-bit counting. It is cleared on every state change.
- `tx_done` stays high until the next accepted request or reset. It is level-visible to the register block at all times.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). No partial frame resumes.

## Timing
- Request sampled at edge k: `tx` falls and `tx_busy` rises after edge k.
- Frame length F = (1 + N + P + S) × CLKS_PER_BIT cycles, where P = `parity_en` and S = 1 + `stop_bit_num`.
- Edge k+F: state returns to IDLE, `tx_busy`=0, `tx_done`=1. `tx` stays 1.
- A new rising edge of `start_tx` at edge k+F or later starts the next frame with no extra idle gap. Software must drop `start_tx` between frames to produce a new edge.
- Each bit holds `tx` stable for exactly CLKS_PER_BIT cycles. Output has no glitches (registered).

## Test plan
All scenarios use CLKS_PER_BIT=4.
- 8N1: `tx_data`=0x55, cfg 11/0/0/0, pulse `start_tx` → `tx` per bit: 0,1,0,1,0,1,0,1,0,1. `tx_busy` high for 40 cycles, then `tx_done`=1.
- 7E2: `tx_data`=0xA3, `data_bit_num`=10, `parity_en`=1, `parity_type`=0, `stop_bit_num`=1 → bits 0,1,1,0,0,0,1,0, parity 1, stop 1,1. Frame is 44 cycles. Bit 7 of `tx_data` is never sent.
- 5O1: `tx_data`=0x1F, cfg 00/0/1/1 → bits 0,1,1,1,1,1, parity 0, stop 1. Frame is 32 cycles.
- Shadowing and ignored start: start 8N1 with 0x00. At cycle 10, change `tx_data` to 0xFF and toggle `start_tx` 0→1 → frame still sends eight 0 data bits and `tx_done` rises only once, at cycle 40.
- Reset mid-frame: assert `reset_n`=0 at cycle 15 of a frame → `tx`=1, `tx_busy`=0, `tx_done`=0 without waiting for a clock edge. After release with `start_tx`=0, the line stays idle.
- Back-to-back: after `tx_done`, lower `start_tx` for 1 cycle, then raise it with 0x0F → `tx_done` clears on acceptance and a second 40-cycle frame follows.
